// File: rtl/object_readout_ctrl.sv
// object_readout_ctrl
//   End-of-frame readout sequencer for the connected-component data table.
//   On frame_done it walks obj_id 1..num_labels. For each id it waits out the
//   table read latency and captures area / x-sum / y-sum. It computes both
//   centroids with two restoring dividers that start together and produce one
//   quotient bit per cycle, then offers the result on a valid/ready port.
//   Objects with zero area are skipped.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   en                  global enable; low freezes every register
//   frame_done          1-cycle pulse, labelling of the frame complete
//   num_labels          label count, sampled on an accepted frame_done
//   obj_id              table read address
//   obj_area/x/y        table read data for obj_id
//   out_valid/ready     result handshake
//   out_id/cx/cy        label and floor centroids of the result
//   busy                high in any state but IDLE
//   done                1-cycle pulse after the sequence finishes
//   overrun             1-cycle pulse after frame_done arrives while busy
module object_readout_ctrl #(
    parameter int unsigned WORD_SIZE = 8,
    parameter int unsigned LOC_W     = 32,
    parameter int unsigned TABLE_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 frame_done,
    input  logic [7:0]           num_labels,
    output logic [WORD_SIZE-1:0] obj_id,
    input  logic [LOC_W-1:0]     obj_area,
    input  logic [LOC_W-1:0]     obj_x,
    input  logic [LOC_W-1:0]     obj_y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_id,
    output logic [LOC_W-1:0]     out_cx,
    output logic [LOC_W-1:0]     out_cy,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] WAIT    = 3'd2;
    localparam logic [2:0] CAPTURE = 3'd3;
    localparam logic [2:0] DIV     = 3'd4;
    localparam logic [2:0] OUT     = 3'd5;
    localparam logic [2:0] FIN     = 3'd6;

    // One down-counter serves both the WAIT and the DIV phases.
    localparam int unsigned CNT_W = $clog2(LOC_W + TABLE_LAT + 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(LOC_W - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((TABLE_LAT >= 2) ? TABLE_LAT - 2 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [WORD_SIZE-1:0] ID_ONE = WORD_SIZE'(1);

    logic [2:0]           state_q, state_d;
    logic [7:0]           n_q, n_d;
    logic [WORD_SIZE-1:0] id_q, id_d;
    logic [WORD_SIZE-1:0] obj_id_q, obj_id_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [LOC_W-1:0]     area_q, area_d;
    logic [LOC_W-1:0]     rem_x_q, rem_x_d, quo_x_q, quo_x_d;
    logic [LOC_W-1:0]     rem_y_q, rem_y_d, quo_y_q, quo_y_d;
    logic                 out_valid_q, out_valid_d;
    logic [WORD_SIZE-1:0] out_id_q, out_id_d;
    logic [LOC_W-1:0]     out_cx_q, out_cx_d, out_cy_q, out_cy_d;
    logic                 done_q, done_d;
    logic                 overrun_q, overrun_d;

    logic [2*LOC_W-1:0]   step_x, step_y;
    logic                 last_id;

    // One restoring-division step. quo holds the not-yet-consumed dividend
    // bits in its upper end and collects quotient bits at the bottom.
    // Returns {remainder, quotient}.
    function automatic logic [2*LOC_W-1:0] div_step(input logic [LOC_W-1:0] rem,
                                                     input logic [LOC_W-1:0] quo,
                                                     input logic [LOC_W-1:0] dsr);
        logic [LOC_W:0]   sh;
        logic             ge;
        logic [LOC_W-1:0] rem_n;
        sh = {rem, quo[LOC_W-1]};
        ge = (sh >= {1'b0, dsr});
        // The difference is below dsr, so the low LOC_W bits are exact.
        rem_n = ge ? (sh[LOC_W-1:0] - dsr) : sh[LOC_W-1:0];
        return {rem_n, quo[LOC_W-2:0], ge};
    endfunction

    assign step_x  = div_step(rem_x_q, quo_x_q, area_q);
    assign step_y  = div_step(rem_y_q, quo_y_q, area_q);
    assign last_id = (id_q == WORD_SIZE'(n_q));

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        id_d        = id_q;
        obj_id_d    = obj_id_q;
        cnt_d       = cnt_q;
        area_d      = area_q;
        rem_x_d     = rem_x_q;
        quo_x_d     = quo_x_q;
        rem_y_d     = rem_y_q;
        quo_y_d     = quo_y_q;
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_cx_d    = out_cx_q;
        out_cy_d    = out_cy_q;
        done_d      = 1'b0;
        overrun_d   = 1'b0;

        if (en) begin
            // A frame_done during FIN is also an overrun; FIN still goes to IDLE.
            overrun_d = frame_done && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (frame_done) begin
                        n_d = num_labels;
                        if (num_labels == 8'd0) begin
                            state_d = FIN;
                        end else begin
                            id_d    = ID_ONE;
                            state_d = ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    obj_id_d = id_q;
                    if (TABLE_LAT <= 1) begin
                        state_d = CAPTURE;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_d = CAPTURE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                CAPTURE: begin
                    area_d  = obj_area;
                    quo_x_d = obj_x;
                    quo_y_d = obj_y;
                    rem_x_d = '0;
                    rem_y_d = '0;
                    cnt_d   = DIV_LOAD;
                    if (obj_area == '0) begin
                        if (last_id) begin
                            state_d = FIN;
                        end else begin
                            id_d    = id_q + ID_ONE;
                            state_d = ISSUE;
                        end
                    end else begin
                        state_d = DIV;
                    end
                end
                DIV: begin
                    {rem_x_d, quo_x_d} = step_x;
                    {rem_y_d, quo_y_d} = step_y;
                    if (cnt_q == '0) begin
                        // Final quotient bit is produced on this edge.
                        out_valid_d = 1'b1;
                        out_id_d    = id_q;
                        out_cx_d    = step_x[LOC_W-1:0];
                        out_cy_d    = step_y[LOC_W-1:0];
                        state_d     = OUT;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        if (last_id) begin
                            state_d = FIN;
                        end else begin
                            id_d    = id_q + ID_ONE;
                            state_d = ISSUE;
                        end
                    end
                end
                FIN: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            n_q         <= '0;
            id_q        <= '0;
            obj_id_q    <= '0;
            cnt_q       <= '0;
            area_q      <= '0;
            rem_x_q     <= '0;
            quo_x_q     <= '0;
            rem_y_q     <= '0;
            quo_y_q     <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_cx_q    <= '0;
            out_cy_q    <= '0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            id_q        <= id_d;
            obj_id_q    <= obj_id_d;
            cnt_q       <= cnt_d;
            area_q      <= area_d;
            rem_x_q     <= rem_x_d;
            quo_x_q     <= quo_x_d;
            rem_y_q     <= rem_y_d;
            quo_y_q     <= quo_y_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_cx_q    <= out_cx_d;
            out_cy_q    <= out_cy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign obj_id    = obj_id_q;
    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_cx    = out_cx_q;
    assign out_cy    = out_cy_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_object_readout_ctrl.sv
// Directed bench for object_readout_ctrl with a result scoreboard and a
// one-register table model (data follows obj_id by one clock).
module tb_object_readout_ctrl;

    localparam int WS = 8;
    localparam int LW = 32;
    localparam int TL = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          frame_done = 1'b0;
    logic [7:0]    num_labels = 8'd0;
    logic [WS-1:0] obj_id;
    logic [LW-1:0] obj_area = '0;
    logic [LW-1:0] obj_x = '0;
    logic [LW-1:0] obj_y = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [WS-1:0] out_id;
    logic [LW-1:0] out_cx;
    logic [LW-1:0] out_cy;
    logic          busy;
    logic          done;
    logic          overrun;

    object_readout_ctrl #(
        .WORD_SIZE (WS),
        .LOC_W     (LW),
        .TABLE_LAT (TL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .frame_done (frame_done),
        .num_labels (num_labels),
        .obj_id     (obj_id),
        .obj_area   (obj_area),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_id     (out_id),
        .out_cx     (out_cx),
        .out_cy     (out_cy),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    logic [LW-1:0] t_area [256];
    logic [LW-1:0] t_x    [256];
    logic [LW-1:0] t_y    [256];

    always @(posedge clk) begin
        obj_area <= t_area[obj_id];
        obj_x    <= t_x[obj_id];
        obj_y    <= t_y[obj_id];
    end

    typedef struct packed {
        logic [WS-1:0] id;
        logic [LW-1:0] cx;
        logic [LW-1:0] cy;
    } res_t;

    res_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted result is popped and compared.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            chk("out_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                res_t e;
                e = exp_q.pop_front();
                chk("out_id", 64'(out_id), 64'(e.id));
                chk("out_cx", 64'(out_cx), 64'(e.cx));
                chk("out_cy", 64'(out_cy), 64'(e.cy));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WS-1:0] id, input logic [LW-1:0] cx,
                        input logic [LW-1:0] cy);
        res_t r;
        r.id = id;
        r.cx = cx;
        r.cy = cy;
        exp_q.push_back(r);
    endtask

    // Returns one cycle into ISSUE (or FIN for n==0).
    task automatic start_frame(input logic [7:0] n);
        num_labels = n;
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int limit, output int k);
        k = 0;
        while (!out_valid && k < limit) begin
            tick();
            k++;
        end
        chk(tag, 64'(out_valid), 64'd1);
    endtask

    task automatic wait_done(input string tag, input int limit);
        int k;
        k = 0;
        while (!done && k < limit) begin
            tick();
            k++;
        end
        chk(tag, 64'(done), 64'd1);
    endtask

    task automatic load_basic();
        for (int i = 0; i < 256; i++) begin
            t_area[i] = '0;
            t_x[i]    = '0;
            t_y[i]    = '0;
        end
        t_area[1] = 4;  t_x[1] = 40; t_y[1] = 8;
        t_area[2] = 0;  t_x[2] = 9;  t_y[2] = 9;
        t_area[3] = 10; t_x[3] = 55; t_y[3] = 100;
    endtask

    task automatic push_basic();
        push(8'd1, 32'd10, 32'd2);
        push(8'd3, 32'd5, 32'd10);
    endtask

    initial begin
        int k;
        load_basic();
        en = 1'b1;
        repeat (3) tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_obj_id", 64'(obj_id), 64'd0);
        chk("rst_out_cx", 64'(out_cx), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        tick();

        // Zero labels: busy for the FIN cycle only, done a cycle later.
        start_frame(8'd0);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_done_early", 64'(done), 64'd0);
        tick();
        chk("t1_busy_off", 64'(busy), 64'd0);
        chk("t1_done", 64'(done), 64'd1);
        tick();
        chk("t1_done_pulse", 64'(done), 64'd0);

        // Three labels, middle one empty.
        out_ready = 1'b1;
        push_basic();
        start_frame(8'd3);
        wait_valid("t2_valid", 100, k);
        chk("t2_latency", 64'(k), 64'd35);
        chk("t2_obj_id", 64'(obj_id), 64'd1);
        wait_done("t2_done", 200);
        chk("t2_drained", 64'(exp_q.size()), 64'd0);
        chk("t2_last_id", 64'(obj_id), 64'd3);
        tick();

        // Back-pressure in OUT.
        out_ready = 1'b0;
        push_basic();
        start_frame(8'd3);
        wait_valid("t3_valid", 100, k);
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", 64'(out_valid), 64'd1);
            chk("t3_hold_id", 64'(out_id), 64'd1);
            chk("t3_hold_cx", 64'(out_cx), 64'd10);
            chk("t3_hold_cy", 64'(out_cy), 64'd2);
            chk("t3_hold_obj_id", 64'(obj_id), 64'd1);
            tick();
        end
        out_ready = 1'b1;
        wait_done("t3_done", 200);
        chk("t3_drained", 64'(exp_q.size()), 64'd0);
        tick();

        // Enable low for 7 cycles during DIV.
        push_basic();
        start_frame(8'd3);
        repeat (15) tick();
        en = 1'b0;
        repeat (7) tick();
        chk("t4_frozen_valid", 64'(out_valid), 64'd0);
        en = 1'b1;
        wait_valid("t4_valid", 100, k);
        chk("t4_latency", 64'(k + 22), 64'd42);
        wait_done("t4_done", 200);
        chk("t4_drained", 64'(exp_q.size()), 64'd0);
        tick();

        // frame_done while busy.
        push_basic();
        start_frame(8'd3);
        repeat (10) tick();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        chk("t5_overrun", 64'(overrun), 64'd1);
        tick();
        chk("t5_overrun_pulse", 64'(overrun), 64'd0);
        wait_valid("t5_valid", 100, k);
        chk("t5_latency", 64'(k + 12), 64'd35);
        wait_done("t5_done", 200);
        chk("t5_drained", 64'(exp_q.size()), 64'd0);
        tick();

        // Reset mid-DIV, then a clean frame.
        push_basic();
        start_frame(8'd3);
        repeat (12) tick();
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_obj_id", 64'(obj_id), 64'd0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        tick();
        push_basic();
        start_frame(8'd3);
        wait_valid("t6_valid", 100, k);
        chk("t6_latency", 64'(k), 64'd35);
        wait_done("t6_done", 200);
        chk("t6_drained", 64'(exp_q.size()), 64'd0);
        tick();

        // Area 1 with an all-ones sum.
        t_area[1] = 1;
        t_x[1]    = 32'hFFFF_FFFF;
        t_y[1]    = 7;
        push(8'd1, 32'hFFFF_FFFF, 32'd7);
        start_frame(8'd1);
        wait_done("tx_done", 200);
        chk("tx_drained", 64'(exp_q.size()), 64'd0);
        tick();

        // 255 labels: must stop at 255; id 0 would yield an extra result.
        for (int i = 0; i < 256; i++) t_area[i] = '0;
        t_area[0] = 1;   t_x[0] = 5;    t_y[0] = 5;
        t_area[255] = 2; t_x[255] = 10; t_y[255] = 20;
        push(8'd255, 32'd5, 32'd10);
        start_frame(8'd255);
        wait_done("t255_done", 3000);
        chk("t255_obj_id", 64'(obj_id), 64'd255);
        repeat (10) tick();
        chk("t255_idle", 64'(busy), 64'd0);
        chk("t255_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
